// File: rtl/dmem_arbiter.sv
// Shares the single-ported data memory between the core load/store path and a host port.
// Optional starvation guard for the host: define DMEM_ARB_STARVE_GUARD_EN.
module dmem_arbiter #(
    parameter int unsigned AW           = 8,
    parameter int unsigned DW           = 8,
    parameter int unsigned STARVE_LIMIT = 4,
    parameter int unsigned BURST_MAX    = 8
) (
    input  logic          clk,
    input  logic          reset,
    // core port
    input  logic          core_rd,
    input  logic          core_wr,
    input  logic [AW-1:0] core_addr,
    input  logic [DW-1:0] core_wdata,
    output logic [DW-1:0] core_rdata,
    output logic          core_stall,
    // host port
    input  logic          host_req,
    input  logic          host_we,
    input  logic [AW-1:0] host_addr,
    input  logic [DW-1:0] host_wdata,
    output logic          host_gnt,
    output logic [DW-1:0] host_rdata,
    output logic          host_rvalid,
    // memory port
    output logic [AW-1:0] mem_addr,
    output logic          mem_rd,
    output logic          mem_wr,
    output logic [DW-1:0] mem_wdata,
    input  logic [DW-1:0] mem_rdata
);

    if (STARVE_LIMIT < 1 || BURST_MAX < 1) begin : g_bad_params
        $error("dmem_arbiter: STARVE_LIMIT and BURST_MAX must be at least 1");
    end

    typedef enum logic {
        StCore = 1'b0,
        StHost = 1'b1
    } state_e;

    localparam int unsigned BW = $clog2(BURST_MAX + 1);
    localparam logic [BW-1:0] BurstLast = BW'(BURST_MAX - 1);

    state_e        state_q, state_d;
    logic [BW-1:0] burst_q, burst_d;
    logic          ca;
    logic          starve_hit;
    logic          host_rvalid_q;
    logic [DW-1:0] host_rdata_q;

    assign ca = core_rd | core_wr;

`ifdef DMEM_ARB_STARVE_GUARD_EN
    localparam int unsigned SW = $clog2(STARVE_LIMIT + 1);
    localparam logic [SW-1:0] StarveLast = SW'(STARVE_LIMIT - 1);

    logic [SW-1:0] starve_q, starve_d;

    assign starve_hit = (starve_q == StarveLast);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            starve_q <= '0;
        end else begin
            starve_q <= starve_d;
        end
    end

    always_comb begin
        starve_d = starve_q;
        if (state_q == StCore) begin
            if (!host_req) begin
                starve_d = '0;
            end else if (ca && !starve_hit) begin
                starve_d = starve_q + 1'b1;
            end
        end else if (!host_req || (ca && burst_q == BurstLast)) begin
            starve_d = '0;
        end
    end
`else
    // Strict core priority: the host only gets in on idle core cycles.
    assign starve_hit = 1'b0;
`endif

    // State register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= StCore;
            burst_q <= '0;
        end else begin
            state_q <= state_d;
            burst_q <= burst_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        burst_d = burst_q;
        unique case (state_q)
            StCore: begin
                if (host_req && (!ca || starve_hit)) begin
                    state_d = StHost;
                end
            end
            StHost: begin
                if (burst_q != BurstLast) begin
                    burst_d = burst_q + 1'b1;
                end
                if (!host_req || (ca && burst_q == BurstLast)) begin
                    state_d = StCore;
                    burst_d = '0;
                end
            end
            default: begin
                state_d = StCore;
                burst_d = '0;
            end
        endcase
    end

    // Output logic
    always_comb begin
        host_gnt   = (state_q == StHost);
        core_rdata = mem_rdata;
        if (state_q == StHost) begin
            mem_addr   = host_addr;
            mem_wdata  = host_wdata;
            mem_rd     = host_req & ~host_we;
            mem_wr     = host_req & host_we;
            core_stall = ca;
        end else begin
            // A simultaneous load and store is treated as a store.
            mem_addr   = core_addr;
            mem_wdata  = core_wdata;
            mem_rd     = core_rd & ~core_wr;
            mem_wr     = core_wr;
            core_stall = 1'b0;
        end
        if (reset) begin
            mem_wr     = 1'b0;
            core_stall = 1'b0;
        end
    end

    // Host read return path
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            host_rvalid_q <= 1'b0;
            host_rdata_q  <= '0;
        end else begin
            host_rvalid_q <= host_gnt & host_req & ~host_we;
            if (host_gnt && host_req && !host_we) begin
                host_rdata_q <= mem_rdata;
            end
        end
    end

    assign host_rvalid = host_rvalid_q;
    assign host_rdata  = host_rdata_q;

endmodule
